// File: rtl/dbg_uart_bridge.sv
// dbg_uart_bridge: UART-to-debug-port initiator.
// Receives 9-byte frames (cmd, addr LSB first, data LSB first) over 8N1 serial,
// drives the debug command until dbg_ready_i, then returns the captured 32-bit
// read word over serial, LSB byte first.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   uart_rx_i/uart_tx_o  serial in/out, 8N1, idle high
//   dbg_cmd_o            command (0x00 = none), valid only while issuing
//   dbg_addr_o/_data_o   address / write data of the last assembled frame
//   dbg_data_i           read data, captured when dbg_ready_i is high
//   busy_o               frame issued and response not yet fully sent
//   err_o                sticky framing / timeout / dropped-byte flag
module dbg_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IDLE_TIMEOUT = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o,
  output logic        err_o
);
  localparam int unsigned    CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]     ToLimit  = 32'(IDLE_TIMEOUT * CLKS_PER_BIT);

  // ---------------- RX deserializer ----------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_done, rx_ferr;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RxStart;
      end
      RxStart: if (rx_cnt_q == HalfLast) begin
        // High at mid start bit is a glitch, not a start.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RxIdle : RxData;
      end
      RxData: if (rx_cnt_q == BitLast) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
      end
      RxStop: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_state_d = RxIdle;
        rx_done    = rx_s2_q;
        rx_ferr    = !rx_s2_q;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------- Frame parser / issue / response ----------------
  typedef enum logic [2:0] {StIdle, StAddr, StData, StIssue, StResp} state_e;
  state_e          state_q, state_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [63:0]     frame_q, frame_d;
  logic [31:0]     addr_q, addr_d, data_q, data_d, resp_q, resp_d;
  logic [31:0]     to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            tx_go_q, tx_go_d;
  logic [1:0]      tx_byte_q, tx_byte_d;
  logic [3:0]      tx_pos_q, tx_pos_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic            tx_q, tx_d;
  logic [7:0]      tx_data;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cmd_d      = cmd_q;
    frame_d    = frame_q;
    addr_d     = addr_q;
    data_d     = data_q;
    resp_d     = resp_q;
    to_cnt_d   = '0;
    err_d      = err_q;
    tx_go_d    = tx_go_q;
    tx_byte_d  = tx_byte_q;
    tx_pos_d   = tx_pos_q;
    tx_cnt_d   = tx_cnt_q;
    case (state_q)
      StIdle: if (rx_done && rx_sh_q != 8'h00) begin
        cmd_d      = rx_sh_q;
        byte_cnt_d = '0;
        state_d    = StAddr;
      end
      StAddr, StData: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (rx_ferr || to_cnt_q > ToLimit) begin
          err_d      = 1'b1;
          byte_cnt_d = '0;
          state_d    = StIdle;
        end else if (rx_done) begin
          to_cnt_d   = '0;
          frame_d    = {rx_sh_q, frame_q[63:8]};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd3) state_d = StData;
          if (byte_cnt_q == 3'd7) begin
            // Outputs only change once a whole frame has arrived.
            addr_d  = frame_q[39:8];
            data_d  = {rx_sh_q, frame_q[63:40]};
            state_d = StIssue;
          end
        end
      end
      StIssue: if (dbg_ready_i) begin
        resp_d    = dbg_data_i;
        tx_go_d   = 1'b0;
        tx_byte_d = '0;
        tx_pos_d  = '0;
        tx_cnt_d  = '0;
        state_d   = StResp;
      end
      StResp: begin
        // First RESP cycle only arms the transmitter; start bit follows.
        if (!tx_go_q) begin
          tx_go_d = 1'b1;
        end else if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_pos_q == 4'd9) begin
            tx_pos_d  = '0;
            tx_byte_d = tx_byte_q + 2'd1;
            if (tx_byte_q == 2'd3) begin
              tx_go_d = 1'b0;
              state_d = StIdle;
            end
          end else begin
            tx_pos_d = tx_pos_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rx_ferr) err_d = 1'b1;
    if (rx_done && (state_q == StIssue || state_q == StResp)) err_d = 1'b1;
  end

  // TX line is registered from next-state values so it is glitch-free.
  assign tx_data = resp_d[{tx_byte_d, 3'b000} +: 8];

  always_comb begin
    tx_d = 1'b1;
    if (state_d == StResp && tx_go_d) begin
      if (tx_pos_d == 4'd0)      tx_d = 1'b0;
      else if (tx_pos_d != 4'd9) tx_d = tx_data[3'(tx_pos_d - 4'd1)];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      cmd_q      <= '0;
      frame_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      resp_q     <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      tx_go_q    <= 1'b0;
      tx_byte_q  <= '0;
      tx_pos_q   <= '0;
      tx_cnt_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      rx_s1_q    <= uart_rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cmd_q      <= cmd_d;
      frame_q    <= frame_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      resp_q     <= resp_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      tx_go_q    <= tx_go_d;
      tx_byte_q  <= tx_byte_d;
      tx_pos_q   <= tx_pos_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign dbg_cmd_o  = (state_q == StIssue) ? cmd_q : 8'h00;
  assign dbg_addr_o = addr_q;
  assign dbg_data_o = data_q;
  assign busy_o     = (state_q == StIssue) || (state_q == StResp);
  assign err_o      = err_q;
  assign uart_tx_o  = tx_q;

endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Directed bench for dbg_uart_bridge with CLKS_PER_BIT=4, IDLE_TIMEOUT=20.
// Inputs change on falling clock edges; outputs are sampled on falling edges.
module tb_dbg_uart_bridge;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int passes = 0;

  dbg_uart_bridge #(
    .CLKS_PER_BIT(CPB),
    .IDLE_TIMEOUT(20)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .uart_rx_i  (rx),
    .uart_tx_o  (tx),
    .dbg_cmd_o  (cmd),
    .dbg_addr_o (addr),
    .dbg_data_o (wdata),
    .dbg_data_i (rdata),
    .dbg_ready_i(ready),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Byte 0 in f[71:64], byte 8 in f[7:0].
  task automatic send_frame(input logic [71:0] f);
    for (int i = 0; i < 9; i++) send_byte(f[71-8*i -: 8], 1'b1);
  endtask

  task automatic wait_cmd(output int n);
    n = 0;
    while (cmd === 8'h00 && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Pulse ready for one cycle; returns on the falling edge after it was sampled.
  task automatic respond(input logic [31:0] v);
    ready = 1'b1;
    rdata = v;
    @(negedge clk);
    ready = 1'b0;
    rdata = 32'h0;
  endtask

  // Called on the edge where cmd has just dropped; records every TX cycle.
  task automatic collect_resp(input logic [31:0] exp, output int bad,
                              output logic busy_last, output logic busy_after,
                              output logic tx_after);
    logic [39:0] line;
    for (int b = 0; b < 4; b++) line[b*10 +: 10] = {1'b1, exp[b*8 +: 8], 1'b0};
    bad = 0;
    busy_last = 1'b0;
    for (int k = 0; k < 40 * CPB; k++) begin
      @(negedge clk);
      if (tx !== line[k / CPB]) bad++;
      if (k == 40 * CPB - 1) busy_last = busy;
    end
    @(negedge clk);
    busy_after = busy;
    tx_after   = tx;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({tx, cmd, addr, wdata, busy, err} !== {1'b1, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset_values: got tx=%b cmd=%h addr=%h data=%h busy=%b err=%b, want 1 00 0 0 0 0",
               tx, cmd, addr, wdata, busy, err);
    else passes++;
  endtask

  task automatic test_write();
    int n, bad, changes;
    logic bl, ba, ta;
    send_frame(72'h01_00_10_00_00_EF_BE_AD_DE);
    wait_cmd(n);
    checks++;
    if ({cmd, addr, wdata} !== {8'h01, 32'h0000_1000, 32'hDEAD_BEEF})
      $display("FAIL write_issue: got cmd=%h addr=%h data=%h, want 01 00001000 deadbeef (waited %0d)",
               cmd, addr, wdata, n);
    else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL write_busy: got %b want 1", busy);
    else passes++;
    changes = 0;
    repeat (5) begin
      @(negedge clk);
      if ({cmd, addr, wdata} !== {8'h01, 32'h0000_1000, 32'hDEAD_BEEF}) changes++;
    end
    checks++;
    if (changes !== 0) $display("FAIL write_hold: %0d cycles changed, want 0", changes);
    else passes++;
    respond(32'hCAFE_F00D);
    checks++;
    if ({cmd, addr, wdata, tx} !== {8'h00, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1})
      $display("FAIL write_release: got cmd=%h addr=%h data=%h tx=%b, want 00 00001000 deadbeef 1",
               cmd, addr, wdata, tx);
    else passes++;
    collect_resp(32'hCAFE_F00D, bad, bl, ba, ta);
    checks++;
    if (bad !== 0) $display("FAIL write_resp: %0d bad tx samples, want 0", bad);
    else passes++;
    checks++;
    if (err !== 1'b0) $display("FAIL write_err: got %b want 0", err);
    else passes++;
  endtask

  task automatic test_read();
    int n, bad;
    logic bl, ba, ta;
    send_frame(72'h02_04_00_00_10_00_00_00_00);
    wait_cmd(n);
    checks++;
    if ({cmd, addr, wdata} !== {8'h02, 32'h1000_0004, 32'h0})
      $display("FAIL read_issue: got cmd=%h addr=%h data=%h, want 02 10000004 00000000 (waited %0d)",
               cmd, addr, wdata, n);
    else passes++;
    respond(32'h1234_5678);
    checks++;
    if ({cmd, tx} !== {8'h00, 1'b1})
      $display("FAIL read_release: got cmd=%h tx=%b, want 00 1", cmd, tx);
    else passes++;
    collect_resp(32'h1234_5678, bad, bl, ba, ta);
    checks++;
    if (bad !== 0) $display("FAIL read_resp_78563412: %0d bad tx samples, want 0", bad);
    else passes++;
    checks++;
    if (bl !== 1'b1) $display("FAIL read_busy_last_stop: got %b want 1", bl);
    else passes++;
    checks++;
    if ({ba, ta} !== 2'b01) $display("FAIL read_busy_after: got busy=%b tx=%b want 0 1", ba, ta);
    else passes++;
  endtask

  task automatic test_ready_early();
    int n, bad;
    logic bl, ba, ta;
    ready = 1'b1;
    rdata = 32'hA5C3_0F96;
    send_frame(72'h0B_20_00_00_00_11_11_11_11);
    wait_cmd(n);
    checks++;
    if ({cmd, addr} !== {8'h0B, 32'h0000_0020})
      $display("FAIL early_issue: got cmd=%h addr=%h, want 0b 00000020", cmd, addr);
    else passes++;
    @(negedge clk);
    ready = 1'b0;
    rdata = 32'h0;
    checks++;
    if (cmd !== 8'h00) $display("FAIL early_one_cycle: got cmd=%h want 00", cmd);
    else passes++;
    collect_resp(32'hA5C3_0F96, bad, bl, ba, ta);
    checks++;
    if (bad !== 0) $display("FAIL early_resp: %0d bad tx samples, want 0", bad);
    else passes++;
  endtask

  task automatic test_framing();
    int n, bad;
    logic bl, ba, ta;
    apply_reset();
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if ({err, cmd, busy} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL framing_err: got err=%b cmd=%h busy=%b, want 1 00 0", err, cmd, busy);
    else passes++;
    send_frame(72'h04_EF_CD_AB_89_04_03_02_01);
    wait_cmd(n);
    checks++;
    if ({cmd, addr, wdata} !== {8'h04, 32'h89AB_CDEF, 32'h0102_0304})
      $display("FAIL framing_next: got cmd=%h addr=%h data=%h, want 04 89abcdef 01020304",
               cmd, addr, wdata);
    else passes++;
    respond(32'h0BAD_F00D);
    collect_resp(32'h0BAD_F00D, bad, bl, ba, ta);
    checks++;
    if (bad !== 0) $display("FAIL framing_resp: %0d bad tx samples, want 0", bad);
    else passes++;
  endtask

  task automatic test_timeout();
    int n, bad;
    logic bl, ba, ta;
    apply_reset();
    send_byte(8'h05, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    repeat (10 * CPB) @(negedge clk);
    checks++;
    if (err !== 1'b0) $display("FAIL timeout_early: got err=%b want 0 after 10 bit-times", err);
    else passes++;
    repeat (11 * CPB) @(negedge clk);
    checks++;
    if ({err, cmd} !== {1'b1, 8'h00})
      $display("FAIL timeout_err: got err=%b cmd=%h, want 1 00", err, cmd);
    else passes++;
    send_frame(72'h06_78_56_34_12_00_00_00_00);
    wait_cmd(n);
    checks++;
    if ({cmd, addr} !== {8'h06, 32'h1234_5678})
      $display("FAIL timeout_next: got cmd=%h addr=%h, want 06 12345678", cmd, addr);
    else passes++;
    respond(32'h0);
    collect_resp(32'h0, bad, bl, ba, ta);
    checks++;
    if (bad !== 0) $display("FAIL timeout_resp: %0d bad tx samples, want 0", bad);
    else passes++;
  endtask

  task automatic test_resync_drop();
    int n, bad;
    logic bl, ba, ta;
    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_frame(72'h07_40_00_00_00_AA_55_AA_55);
    wait_cmd(n);
    checks++;
    if ({cmd, addr, wdata, err} !== {8'h07, 32'h0000_0040, 32'h55AA_55AA, 1'b0})
      $display("FAIL resync_issue: got cmd=%h addr=%h data=%h err=%b, want 07 00000040 55aa55aa 0",
               cmd, addr, wdata, err);
    else passes++;
    respond(32'h600D_CAFE);
    fork
      collect_resp(32'h600D_CAFE, bad, bl, ba, ta);
      begin
        repeat (4) @(negedge clk);
        send_byte(8'h5A, 1'b1);
      end
    join
    checks++;
    if (bad !== 0) $display("FAIL drop_resp: %0d bad tx samples, want 0", bad);
    else passes++;
    checks++;
    if ({err, ba} !== 2'b10) $display("FAIL drop_err: got err=%b busy=%b, want 1 0", err, ba);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int n, bad;
    logic bl, ba, ta;
    // err is still set from the previous test here.
    send_frame(72'h08_44_33_22_11_01_00_00_00);
    wait_cmd(n);
    rst = 1'b1;
    #1;
    checks++;
    if ({tx, cmd, addr, wdata, busy, err} !== {1'b1, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset_mid_issue: got tx=%b cmd=%h addr=%h data=%h busy=%b err=%b, want 1 00 0 0 0 0",
               tx, cmd, addr, wdata, busy, err);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(72'h09_00_01_00_00_00_00_00_00);
    wait_cmd(n);
    respond(32'hFFFF_0000);
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) $display("FAIL resp_start_bit: got tx=%b want 0", tx);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({tx, busy, cmd} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL reset_mid_resp: got tx=%b busy=%b cmd=%h, want 1 0 00", tx, busy, cmd);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(72'h0A_0C_0B_0A_09_DD_CC_BB_AA);
    wait_cmd(n);
    checks++;
    if ({cmd, addr, wdata} !== {8'h0A, 32'h090A_0B0C, 32'hAABB_CCDD})
      $display("FAIL reset_next_issue: got cmd=%h addr=%h data=%h, want 0a 090a0b0c aabbccdd",
               cmd, addr, wdata);
    else passes++;
    respond(32'h8421_1248);
    collect_resp(32'h8421_1248, bad, bl, ba, ta);
    checks++;
    if ({bad, err, ba} !== {32'd0, 1'b0, 1'b0})
      $display("FAIL reset_next_resp: got bad=%0d err=%b busy=%b, want 0 0 0", bad, err, ba);
    else passes++;
  endtask

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    rdata = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_ready_early();
    test_framing();
    test_timeout();
    test_resync_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
